// File: rtl/sdram_memtest_pkg.sv
// rtl/sdram_memtest_pkg.sv - shared states, LFSR tap table and data pattern for the SDRAM memory tester
package sdram_memtest_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_BATCH_END,
    S_FIN
  } state_t;

  // Tap masks: bit (n-1) set for each tap n of a maximal-length polynomial
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0004_0023;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0000;
    endcase
  endfunction

  // Low data slice ^ high address slice ^ batch index, so reads replay without storage
  function automatic logic [15:0] data_pattern(input logic [31:0] a, input logic [31:0] b,
                                               input int aw, input int dw);
    logic [31:0] mask;
    mask = (32'h1 << dw) - 32'h1;
    return 16'((a & mask) ^ ((a >> (aw - dw)) & mask) ^ (b & mask));
  endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// rtl/sdram_addr_gen.sv - LFSR/sequential address generator with checkpoint save and restore
module sdram_addr_gen
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_seed,
  input  logic              i_step,
  input  logic              i_save,
  input  logic              i_restore,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] TAPS = ADDR_W'(lfsr_taps(ADDR_W));

  logic              r_mode;
  logic [ADDR_W-1:0] r_state;
  logic [ADDR_W-1:0] r_ckpt;
  logic [ADDR_W-1:0] w_seed;
  logic [ADDR_W-1:0] w_next;

  // An all-zero LFSR would lock up, so seed 0 becomes 1 in LFSR mode
  assign w_seed = (!i_mode && i_seed == '0) ? ADDR_W'(1) : i_seed;
  assign w_next = r_mode ? r_state + ADDR_W'(1)
                         : {r_state[ADDR_W-2:0], ^(r_state & TAPS)};
  assign o_addr = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= 1'b0;
      r_state <= '0;
      r_ckpt  <= '0;
    end else if (i_load) begin
      r_mode  <= i_mode;
      r_state <= w_seed;
      r_ckpt  <= w_seed;
    end else begin
      if (i_restore)   r_state <= r_ckpt;
      else if (i_step) r_state <= w_next;
      if (i_save)      r_ckpt  <= r_state;
    end
  end

endmodule

// File: rtl/sdram_memtest.sv
// rtl/sdram_memtest.sv - batch write/read-back traffic generator and checker for the SDRAM controller
module sdram_memtest
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 8,
  parameter int BATCH       = 4,
  parameter int NUM_BATCHES = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [ADDR_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_wr,
  input  logic              rdy,
  input  logic              val,
  input  logic [DATA_W-1:0] data_rd
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t              r_state, w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [8:0]          r_cnt;
  logic [31:0]         r_batch;
  logic [15:0]         r_err_count;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [DATA_W-1:0]   r_err_exp, r_err_got;
  logic                r_timeout, r_pass;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_pattern;
  logic                w_load, w_step, w_save, w_restore, w_cnt_inc, w_cnt_clr;
  logic                w_batch_inc, w_check, w_set_to, w_expire, w_last, w_pass_now;

  sdram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_mode   (mode),
    .i_seed   (seed),
    .i_step   (w_step),
    .i_save   (w_save),
    .i_restore(w_restore),
    .o_addr   (w_addr)
  );

  assign w_pattern  = DATA_W'(data_pattern(32'(w_addr), r_batch, ADDR_W, DATA_W));
  assign w_expire   = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_last     = (r_cnt == 9'(BATCH - 1));
  assign w_pass_now = (r_err_count == '0) && !r_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A handshake arriving on the expiry cycle wins over the timeout
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_save      = 1'b0;
    w_restore   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_batch_inc = 1'b0;
    w_check     = 1'b0;
    w_set_to    = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_load = 1'b1;
        w_next = S_WR;
      end
      S_WR: if (rdy) begin
        w_step = 1'b1;
        if (w_last) begin
          w_restore = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_RD_REQ;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end else if (w_expire) begin
        w_set_to = 1'b1;
        w_next   = S_FIN;
      end
      S_RD_REQ: if (rdy) begin
        w_next = S_RD_WAIT;
      end else if (w_expire) begin
        w_set_to = 1'b1;
        w_next   = S_FIN;
      end
      S_RD_WAIT: if (val) begin
        w_check = 1'b1;
        w_step  = 1'b1;
        if (w_last) begin
          w_cnt_clr = 1'b1;
          w_next    = S_BATCH_END;
        end else begin
          w_cnt_inc = 1'b1;
          w_next    = S_RD_REQ;
        end
      end else if (w_expire) begin
        w_set_to = 1'b1;
        w_next   = S_FIN;
      end
      S_BATCH_END: begin
        w_batch_inc = 1'b1;
        if ((NUM_BATCHES != 0 && r_batch + 32'd1 == 32'(NUM_BATCHES)) || stop) begin
          w_next = S_FIN;
        end else begin
          w_save = 1'b1;
          w_next = S_WR;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait      <= '0;
      r_cnt       <= '0;
      r_batch     <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_err_exp   <= '0;
      r_err_got   <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_next != r_state) r_wait <= '0;
      else if (r_state inside {S_WR, S_RD_REQ, S_RD_WAIT}) r_wait <= r_wait + WAIT_W'(1);
      if (w_load) begin
        r_cnt       <= '0;
        r_batch     <= '0;
        r_err_count <= '0;
        r_err_addr  <= '0;
        r_err_exp   <= '0;
        r_err_got   <= '0;
        r_timeout   <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        if (w_cnt_clr)      r_cnt <= '0;
        else if (w_cnt_inc) r_cnt <= r_cnt + 9'd1;
        if (w_batch_inc) r_batch <= r_batch + 32'd1;
        if (w_set_to) r_timeout <= 1'b1;
        if (w_check && data_rd != w_pattern) begin
          if (r_err_count == '0) begin
            r_err_addr <= w_addr;
            r_err_exp  <= w_pattern;
            r_err_got  <= data_rd;
          end
          if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end
        if (r_state == S_FIN) r_pass <= w_pass_now;
      end
    end
  end

  assign busy      = r_state inside {S_WR, S_RD_REQ, S_RD_WAIT, S_BATCH_END};
  assign done      = (r_state == S_FIN);
  assign pass      = done ? w_pass_now : r_pass;
  assign timeout   = r_timeout;
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;
  assign err_exp   = r_err_exp;
  assign err_got   = r_err_got;
  // Requests drop combinationally so reset cancels them within the reset cycle
  assign wr        = (r_state == S_WR) && !rst;
  assign rd        = (r_state == S_RD_REQ) && !rst;
  assign addr      = w_addr;
  assign data_wr   = w_pattern;

endmodule

// File: doc/sdram_memtest.md
Name: sdram_memtest

Overview:
- Synthesizable self-checking traffic generator/checker for the byte-wide SDRAM controller request interface (wr/rd/addr/data_wr/rdy/val/data_rd).
- Writes a batch of pseudo-random or sequential addresses, then reads them back and compares; repeats for a programmable number of batches.
- Replaces bench-only stimulus, so memory tests run on hardware and in simulation; parametrised in address/data width, batch depth, timeout and pattern mode.

Parameters:
ADDR_W, 24, controller byte-address width (8..32)
DATA_W, 8, controller data width (8 or 16; DATA_W <= ADDR_W)
BATCH, 4, writes per batch before read-back (1..256)
NUM_BATCHES, 16, batches per run; 0 = run until stop
TIMEOUT, 1024, max cycles waiting on rdy or val before a timeout error

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
stop  in  1  level; run ends after the current batch (needed when NUM_BATCHES=0)
mode  in  1  0 = LFSR addresses, 1 = sequential addresses from seed
seed  in  ADDR_W  initial LFSR state/base address (0 is replaced by 1 in LFSR mode)
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  valid after done: 1 when err_count==0 and no timeout
timeout  out  1  sticky; rdy or val wait exceeded TIMEOUT
err_count  out  16  mismatches this run, saturating at 16'hFFFF
err_addr  out  ADDR_W  address of first mismatch
err_exp  out  DATA_W  expected data at first mismatch
err_got  out  DATA_W  read data at first mismatch
wr  out  1  write request
rd  out  1  read request
addr  out  ADDR_W  request address
data_wr  out  DATA_W  write data
rdy  in  1  controller accepts the request in the cycle rdy=1
val  in  1  data_rd valid (one cycle)
data_rd  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0; FSM in IDLE; wr/rd drop in the reset cycle, even mid-transaction.
- Handshake: the request is held (wr or rd, addr, data_wr stable) until a posedge with rdy=1; that edge accepts it. wr and rd are never both high. Only one read is outstanding at a time; the next rd is issued only after val.
- Address sequence:
  - mode 0: Fibonacci LFSR of ADDR_W bits, maximal-length taps from the package. Next address = one LFSR step.
  - mode 1: address increments by 1, wrapping at 2^ADDR_W. This exercises both bytes of a word.
- Data = addr[DATA_W-1:0] ^ addr[ADDR_W-1 -: DATA_W] ^ batch_idx[DATA_W-1:0]. This makes each batch distinct and the pattern replayable without storage.
- At batch start, the address generator state is saved in ckpt. The read phase restores ckpt and replays the same BATCH addresses in the same order.
- FSM states:
  - IDLE: on start, latch seed, clear errors, timeout and batch_idx; busy=1; go to WR.
  - WR: hold wr; on rdy, advance the address and the write counter. After BATCH acceptances, restore ckpt and go to RD_REQ.
  - RD_REQ: hold rd; on rdy go to RD_WAIT.
  - RD_WAIT: on val, compare data_rd with expected. On mismatch, increment err_count (saturating); if this is the first error, capture err_addr/err_exp/err_got. Advance the read counter. If more reads remain go to RD_REQ, else go to BATCH_END.
  - BATCH_END: increment batch_idx. If batch_idx==NUM_BATCHES (NUM_BATCHES≠0) or stop=1, go to FIN. Otherwise save ckpt from the current generator state and go to WR.
  - FIN: done=1 for one cycle; pass = (err_count==0 && !timeout); busy=0; go to IDLE.
- Wait counter: cleared on every state change, incremented in WR, RD_REQ and RD_WAIT. Reaching TIMEOUT sets timeout, drops wr/rd and goes to FIN.
- Boundaries:
  - start while busy is ignored.
  - A val outside RD_WAIT is ignored.
  - val in the same cycle as timeout expiry counts as received.
  - stop sampled only in BATCH_END.
  - err/pass outputs hold until the next start.

Decomposition:
- Package sdram_memtest_pkg: state enum, lfsr_taps(width) constant function (table for 8..32), data_pattern(addr, batch) function.
- Sub-module sdram_addr_gen: LFSR/sequential generator with load, step, save and restore ports.

Test Plan:
- Behavioural controller model (2-cycle rdy, 4-cycle val, backing array): ADDR_W=24, mode 0, seed 24'h1, NUM_BATCHES=4 -> 16 writes, 16 reads, done, pass=1, err_count=0.
- Model corrupts bit 0 of the 3rd read in batch 0 -> err_count=1; err_addr equals the 3rd LFSR address; err_got = err_exp ^ 8'h01; pass=0.
- mode 1, seed 24'hFFFFFE, BATCH=4 -> addresses FFFFFE, FFFFFF, 000000, 000001 for both writes and read replay (wrap).
- Model never asserts val, TIMEOUT=1024 -> timeout=1, rd=0 by cycle 1025 of the wait, done pulse, pass=0.
- NUM_BATCHES=0, stop raised during batch 2 -> run ends after batch 2 read-back; exactly 3 done cycles' worth of batches completed, then a single done pulse.
- rst asserted mid-WR with wr=1 -> wr=0 and busy=0 next cycle, all outputs 0; a new start then runs normally to pass=1.
